// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: scoreboard entry layout, forward-select encoding
// and the pipeline-depth constants the hazard unit is sized from.
package cpu_types_pkg;

  localparam int unsigned NREGS = 32;
  localparam int unsigned REGW  = $clog2(NREGS);
  localparam int unsigned DEPTH = 3;
  localparam int unsigned FWDW  = $clog2(DEPTH + 1);

  typedef logic [REGW-1:0] reg_idx_t;
  typedef logic [FWDW-1:0] fwd_sel_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dst;
    fwd_sel_t avail;
  } sb_entry_t;

  localparam fwd_sel_t FWD_RF     = FWDW'(0);
  localparam fwd_sel_t AVAIL_ALU  = FWDW'(0);
  localparam fwd_sel_t AVAIL_LOAD = FWDW'(1);

endpackage

// File: rtl/sb_match.sv
// Priority match of one source operand against every scoreboard slot;
// the youngest (lowest-index) matching slot wins.
module sb_match
  import cpu_types_pkg::*;
(
  input  reg_idx_t                i_src,
  input  logic                    i_used,
  input  sb_entry_t [DEPTH-1:0]   i_slots,
  output logic                    o_hit,
  output fwd_sel_t                o_idx,
  output logic                    o_ready
);

  // Scan oldest to youngest so the youngest hit overwrites older ones.
  always_comb begin
    o_hit   = 1'b0;
    o_idx   = FWD_RF;
    o_ready = 1'b0;
    if (i_used && (i_src != '0)) begin
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (i_slots[s].valid && (i_slots[s].dst == i_src)) begin
          o_hit   = 1'b1;
          o_idx   = FWDW'(s);
          o_ready = (FWDW'(s) >= i_slots[s].avail);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: tracks in-flight writes over DEPTH stages and
// drives stall / forward selects. HAZARD_MULDIV_EN adds the multi-cycle unit guard.
module hazard_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int unsigned NSRC = 2
`ifdef HAZARD_MULDIV_EN
  ,
  parameter int unsigned MULDIV_LAT = 8
`endif
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   id_valid,
  input  logic [NSRC*REGW-1:0]   id_src,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic                   id_wen,
  input  logic [REGW-1:0]        id_dst,
  input  logic [FWDW-1:0]        id_avail,
  input  logic                   freeze,
  input  logic                   flush,
`ifdef HAZARD_MULDIV_EN
  input  logic                   id_mdiv,
  input  logic                   mdiv_done_early,
  output logic                   mdiv_busy,
`endif
  output logic                   stall,
  output logic [NSRC*FWDW-1:0]   fwd_sel,
  output logic                   sb_busy
);

  sb_entry_t [DEPTH-1:0] r_slots;
  logic [NSRC-1:0]       w_hit;
  logic [NSRC-1:0]       w_ready;
  logic [NSRC-1:0]       w_haz;
  fwd_sel_t [NSRC-1:0]   w_idx;
  logic                  w_issue;
  logic                  w_struct_haz;
  sb_entry_t             w_new;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    sb_match u_match (
      .i_src   (id_src[i*REGW +: REGW]),
      .i_used  (id_src_used[i]),
      .i_slots (r_slots),
      .o_hit   (w_hit[i]),
      .o_idx   (w_idx[i]),
      .o_ready (w_ready[i])
    );
    assign w_haz[i] = w_hit[i] & ~w_ready[i];
    assign fwd_sel[i*FWDW +: FWDW] = (w_hit[i] && w_ready[i]) ? (w_idx[i] + FWDW'(1)) : FWD_RF;
  end

`ifdef HAZARD_MULDIV_EN
  localparam int unsigned MDIVW = $clog2(MULDIV_LAT + 1);
  logic [MDIVW-1:0] r_mdiv_cnt;

  assign mdiv_busy    = (r_mdiv_cnt != '0);
  assign w_struct_haz = id_mdiv & mdiv_busy;

  // Early completion clears even while frozen; otherwise count only when the pipe moves.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mdiv_cnt <= '0;
    end else if (mdiv_done_early) begin
      r_mdiv_cnt <= '0;
    end else if (!freeze) begin
      if (w_issue && id_mdiv) begin
        r_mdiv_cnt <= MDIVW'(MULDIV_LAT);
      end else if (r_mdiv_cnt != '0) begin
        r_mdiv_cnt <= r_mdiv_cnt - MDIVW'(1);
      end
    end
  end
`else
  assign w_struct_haz = 1'b0;
`endif

  assign stall   = id_valid & ((|w_haz) | w_struct_haz);
  assign w_issue = id_valid & ~stall & ~flush;

  // Entry for the instruction leaving decode; writes to r0 never become valid.
  always_comb begin
    w_new.valid = id_wen & (id_dst != '0);
    w_new.dst   = id_dst;
    w_new.avail = id_avail;
`ifdef HAZARD_MULDIV_EN
    if (id_mdiv) begin
      w_new.avail = FWDW'(DEPTH - 1);
    end
`endif
  end

  always_comb begin
    sb_busy = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      sb_busy = sb_busy | r_slots[s].valid;
    end
  end

  // Shift when the pipe moves; under freeze only a flush may kill slot 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_slots <= '0;
    end else if (!freeze) begin
      for (int s = DEPTH - 1; s > 0; s--) begin
        r_slots[s] <= r_slots[s-1];
      end
      r_slots[0] <= w_issue ? w_new : '0;
    end else if (flush) begin
      r_slots[0].valid <= 1'b0;
    end
  end

  a_avail_legal : assert property (@(posedge CLK) disable iff (RST)
    id_valid |-> (id_avail < FWDW'(DEPTH)))
    else $error("id_avail out of range: %0d", id_avail);

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational hazard/forward unit.
- Tracks in-flight register writes in a per-stage shift scoreboard covering DEPTH post-decode stages.
- Per-producer "available-from" stage, so ALU, load and long-latency producers are all handled uniformly.
- Sits beside the decode stage. Drives stall, per-operand forward selects and bubble insertion for any pipeline depth or operand count.

Parameters:
- NREGS, 32, architectural register count (register 0 hard-wired zero).
- REGW, 5, register index width, equal to clog2(NREGS).
- DEPTH, 3, number of tracked stages after decode (slot 0 = EX, slot 1 = MEM, slot 2 = WB).
- NSRC, 2, source operands checked per decoded instruction.
- FWDW, 2, forward-select width, equal to clog2(DEPTH+1).
- MULDIV_LAT, 8, multi-cycle unit occupancy in cycles (used only with the optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_src  in  NSRC*REGW  source register indices, operand i at bits [i*REGW +: REGW].
- id_src_used  in  NSRC  operand i is actually read.
- id_wen  in  1  decoded instruction writes a register.
- id_dst  in  REGW  destination register index.
- id_avail  in  FWDW  first slot index from which the result is forwardable (ALU 0, load 1).
- freeze  in  1  external memory wait; scoreboard holds.
- flush  in  1  squash the instruction in decode and the one in slot 0.
- stall  out  1  hold PC and IF/ID, insert a bubble.
- fwd_sel  out  NSRC*FWDW  per operand: 0 = register file, s+1 = forward from slot s.
- sb_busy  out  1  any slot valid (drain indicator for halt).

Behaviour:
- State per slot s: valid, dst (REGW bits), avail (FWDW bits).
- Reset: all slots invalid and the mdiv counter is 0. stall, fwd_sel and sb_busy are combinational and therefore read 0 after reset.
- Match for operand i:
  - id_src_used[i] is set, src is not 0, and the slot is valid with dst == src.
  - The youngest matching slot (lowest s) wins; older matches are ignored.
- No match: fwd_sel[i] = 0.
- Match with s >= slot.avail: fwd_sel[i] = s+1.
- Match with s < slot.avail: operand i is hazarded.
- stall = id_valid and any hazarded operand (mdiv term added by the optional feature). stall is independent of freeze.
- fwd_sel is still computed while stall is asserted; datapath ignores it.
- Slot update at the rising edge, freeze = 0:
  - Slots shift: slot s+1 takes slot s; slot DEPTH-1 retires.
  - Slot 0 loads {id_wen and id_dst != 0, id_dst, id_avail} when id_valid, no stall and no flush.
  - Otherwise slot 0 loads a bubble (valid = 0).
- freeze = 1: all slots hold. If flush is also set, slot 0 becomes invalid; flush overrides freeze for slot 0 only.
- Write to register 0 never creates a valid entry.
- id_avail >= DEPTH is illegal and is asserted against in simulation.
- Latency: combinational ID-to-output; the scoreboard reflects an issued instruction in the next cycle.
- Reset mid-operation clears every slot immediately; no partial shift.
- Equivalence: DEPTH=3 with avail 0/1 reproduces the legacy ALU forward and load-use single stall.

Optional Feature:
- Macro: HAZARD_MULDIV_EN.
- Enabled:
  - Adds inputs id_mdiv (1) and mdiv_done_early (1), plus a counter of width clog2(MULDIV_LAT+1).
  - An issued id_mdiv instruction (not stalled, not flushed, not frozen) loads the counter with MULDIV_LAT. Its slot entry is marked avail = DEPTH-1, i.e. forward only from the last slot.
  - The counter decrements each non-freeze cycle while nonzero and clears when mdiv_done_early is set.
  - stall also asserts when id_valid and id_mdiv and the counter is nonzero (structural hazard).
  - The counter is readable as mdiv_busy = (counter != 0).
- Disabled: the ports are absent, no counter exists, and mdiv_busy does not exist.

Decomposition:
- Shared package cpu_types_pkg gets:
  - a scoreboard entry struct {valid, dst, avail};
  - fwd_sel_t (FWDW bits);
  - constants FWD_RF = 0, AVAIL_ALU = 0, AVAIL_LOAD = 1.
- One sub-module, sb_match: combinational priority match of one operand against all slots, returning hit, slot index and ready. Instantiate NSRC times via generate.

Test Plan:
- Reset with id_valid=1, id_src={r3,r2} -> stall=0, fwd_sel={0,0}, sb_busy=0.
- Issue add r4 (avail 0), next cycle sub using r4 as operand 0 -> fwd_sel[0]=1, stall=0. One cycle later -> fwd_sel[0]=2.
- Issue lw r5 (avail 1), next cycle dependent on r5 -> stall=1 for exactly one cycle, bubble in slot 0. Then fwd_sel=2, stall=0.
- Back-to-back writes to r6 in slot 0 and slot 1, consumer reads r6 -> fwd_sel=1 (youngest wins). Reading r0 with a pending write to r0 -> fwd_sel=0.
- lw r7 in slot 0 with freeze=1 for 3 cycles and a dependent consumer in decode -> stall held 3+1 cycles, slots unchanged during freeze. flush during freeze -> slot 0 invalid, dependent stall drops.
- HAZARD_MULDIV_EN, MULDIV_LAT=8: mult issued, second mult follows -> stall for 8 cycles. mdiv_done_early at cycle 3 -> stall drops the next cycle.
